muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit in the EX stage, holding the architectural HI/LO registers. Consumes the forwarded `rs`/`rt` operand values produced by the EX-stage operand forwarding logic. Executes MULT/MULTU/DIV/DIVU over multiple cycles. Requests a pipeline stall when EX presents a new HI/LO operation or an HI/LO read while an operation is in flight.

## Interface

Parameters:
- `ITER`, 32: iteration cycles per mul/div; fixed at 32 for 32-bit operands.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  EX holds a MULT/MULTU/DIV/DIVU/MTHI/MTLO instruction this cycle.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored.
- `rs_val`  in  32  forwarded rs operand (dividend / multiplicand / MTxx source).
- `rt_val`  in  32  forwarded rt operand (divisor / multiplier).
- `ex_exception`  in  8  EX exception code; a nonzero value suppresses `start`.
- `rd_req`  in  1  EX holds MFHI/MFLO this cycle.
- `flush`  in  1  pipeline flush; aborts an in-flight operation.
- `busy`  out  1  state != IDLE.
- `stall_req`  out  1  combinational: `busy && (start || rd_req)`.
- `done`  out  1  one-cycle pulse when HI/LO have been updated by mul/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation

- States:
  - IDLE → RUN on accepted mul/div start.
  - RUN → FIX after 32 iterations (5-bit counter, 0..31).
  - FIX → IDLE unconditionally.
- Accept condition: `start && !busy && !flush && ex_exception==0 && op<=5`. Any other `start` has no effect.
- MTHI/MTLO: on the accept edge, write `rs_val` to HI or LO. State stays IDLE, `done` not pulsed.
- On mul/div accept:
  - Latch operand magnitudes: signed ops take the absolute value as 32-bit unsigned, so |0x80000000| = 0x80000000.
  - Latch the result sign flags: product/quotient sign = `rs[31]^rt[31]`; remainder sign = `rs[31]`. Unsigned ops force both sign flags to 0.
  - Latch a divide-by-zero flag: `rt_val==0`.
- Multiply: shift-add, one multiplier bit per RUN cycle, 64-bit accumulator.
- Divide: restoring radix-2, one quotient bit per RUN cycle, 33-bit partial remainder.
- FIX:
  - Apply two's-complement negation per the sign flags.
  - MUL writes `{hi,lo}` = 64-bit product.
  - DIV writes lo = quotient, hi = remainder.
- Divide by zero, both DIV and DIVU: full latency, no fixup; hi = original `rs_val`, lo = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (no trap).
- `flush`:
  - Forces IDLE at the next edge from any state; HI/LO unchanged, no `done`.
  - A `flush` in the FIX cycle wins: no HI/LO write.
  - `flush` has priority over `start`.
- `rst`: state IDLE, counter 0, hi = lo = 0, busy = 0, done = 0. Reset mid-operation discards it.
- `hi`/`lo` are the register values; EX selects them for MFHI/MFLO only when `stall_req` is low.

## Timing

- Accept edge E0 → `busy` high from E0 through E33 (33 cycles).
- RUN iterations occur on edges E1..E32; FIX edge E33 writes HI/LO.
- `done` is high for exactly the cycle after E33 (registered), coincident with `busy` = 0.
- New mul/div may be accepted on E34 (first cycle `busy` = 0); back-to-back throughput 34 cycles/op.
- MTHI/MTLO latency 1: the value is visible on `hi`/`lo` the cycle after the accept edge.
- `stall_req` is combinational in the same cycle as `start`/`rd_req`. The pipeline holds EX and re-presents the instruction until `stall_req` drops.
- `rd_req` while IDLE: no stall; reads current HI/LO.

## Test plan

- MULT rs=0xFFFFFFFF rt=0x00000002 → done at E33+; hi=0xFFFFFFFF lo=0xFFFFFFFE. MULTU same operands → hi=0x00000001 lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7) rt=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU rs=100 rt=7 → lo=14 hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000 hi=0.
- DIVU rs=0x12345678 rt=0 → after 33 busy cycles: hi=0x12345678 lo=0xFFFFFFFF, done pulsed once.
- MULT started, `rd_req` asserted at E5 → stall_req=1 every cycle through E33; stall_req=0 in the done cycle, and hi/lo then hold the product.
- MULT started, flush at E10 → busy=0 at E11, no done, hi/lo keep prior values. Flush in FIX cycle → no write. Start with ex_exception=0x04 → ignored, busy stays 0.
- MTLO rs=0xCAFEBABE while idle → lo=0xCAFEBABE next cycle. MTHI while busy → stall_req=1, hi unchanged until re-presented after idle. rst at E20 → all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per RUN cycle, sign fixup in FIX.
module muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [7:0]  ex_exception,
    input  logic        rd_req,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] rs_orig_q, rs_orig_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        accept;
    logic        signed_op;
    logic [31:0] mag_rs, mag_rt;
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic [63:0] prod_neg;

    assign busy      = (state_q != IDLE);
    assign stall_req = busy && (start || rd_req);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    assign accept    = start && !busy && !flush && (ex_exception == 8'd0) && (op <= 3'd5);
    assign signed_op = (op == 3'd0) || (op == 3'd2);
    assign mag_rs    = (signed_op && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    assign mag_rt    = (signed_op && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    // Divide: acc holds {partial remainder, remaining dividend bits / quotient bits}.
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign prod_neg  = ~acc_q + 64'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        rs_orig_d  = rs_orig_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op[2]) begin
                        if (op[0]) lo_d = rs_val;
                        else       hi_d = rs_val;
                    end else begin
                        state_d    = RUN;
                        cnt_d      = 5'd0;
                        is_div_d   = op[1];
                        rs_orig_d  = rs_val;
                        div_zero_d = (rt_val == 32'd0);
                        neg_res_d  = signed_op && (rs_val[31] ^ rt_val[31]);
                        neg_rem_d  = signed_op && rs_val[31];
                        opnd_d     = op[1] ? mag_rt : mag_rs;
                        acc_d      = {32'd0, (op[1] ? mag_rs : mag_rt)};
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    else               acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                end else if (div_zero_q) begin
                    hi_d = rs_orig_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    lo_d = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                    hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush beats everything, including the FIX-cycle write.
        if (flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            acc_q      <= 64'd0;
            opnd_q     <= 32'd0;
            rs_orig_q  <= 32'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            rs_orig_q  <= rs_orig_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pairs are queued at issue
// and popped by a monitor whenever done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [7:0]  ex_exception;
    logic        rd_req;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .ex_exception(ex_exception), .rd_req(rd_req),
        .flush(flush), .busy(busy), .stall_req(stall_req), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL done_unexpected: got hi=%h lo=%h, required no done", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    errors++;
                    $display("[TB] FAIL result: got hi=%h lo=%h, required hi=%h lo=%h",
                             hi, lo, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Drives a one-cycle start at a negedge; returns at the negedge after the accept edge.
    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [7:0] exc);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; ex_exception = exc;
        @(negedge clk);
        start = 1'b0; ex_exception = 8'd0;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int k;
        exp_q.push_back({eh, el});
        apply_stimulus(o, a, b, 8'd0);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_output({name, "_latency"}, 32'(k), 32'd33);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
        ex_exception = 8'd0; rd_req = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_output("reset_hi", hi, 32'd0);
        check_output("reset_lo", lo, 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);

        run_op("mult_neg1x2", 3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu_ffx2", 3'd1, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE);
        run_op("mult_min_sq", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run_op("multu_max_sq", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_m3x5", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_min_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("divu_by0", 3'd3, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        run_op("div_neg_by0", 3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // rd_req from E5 on: stall held until the done cycle.
        exp_q.push_back({32'd0, 32'd42});
        apply_stimulus(3'd0, 32'd6, 32'd7, 8'd0);
        for (k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k >= 5) rd_req = 1'b1;
            #1;
            if (k >= 5) check_output("rd_stall", 32'(stall_req), (k <= 32) ? 32'd1 : 32'd0);
        end
        check_output("rd_done_cycle", 32'(done), 32'd1);
        check_output("rd_lo", lo, 32'd42);
        rd_req = 1'b0;
        #1 check_output("idle_rd_stall", 32'(stall_req), 32'd0);

        // MTHI presented while busy is re-presented until the stall drops.
        exp_q.push_back({32'd0, 32'd12});
        apply_stimulus(3'd1, 32'd3, 32'd4, 8'd0);
        for (k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 3) begin start = 1'b1; op = 3'd4; rs_val = 32'hDEADBEEF; end
            #1;
            if (k == 3)  check_output("mthi_busy_stall", 32'(stall_req), 32'd1);
            if (k == 33) check_output("mthi_hi_held", hi, 32'd0);
            if (k == 34) begin
                start = 1'b0;
                check_output("mthi_hi_after", hi, 32'hDEADBEEF);
            end
        end

        // Flush sampled at E10 aborts the multiply.
        apply_stimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd0);
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            flush = (k == 9);
        end
        check_output("flush_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check_output("flush_hi", hi, 32'hDEADBEEF);
        check_output("flush_lo", lo, 32'd12);

        // Flush during the FIX cycle suppresses the write.
        apply_stimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd0);
        for (k = 1; k <= 33; k++) begin
            @(negedge clk);
            flush = (k == 32);
        end
        check_output("fixflush_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check_output("fixflush_hi", hi, 32'hDEADBEEF);
        check_output("fixflush_lo", lo, 32'd12);

        apply_stimulus(3'd0, 32'd5, 32'd5, 8'h04);
        check_output("exc_busy", 32'(busy), 32'd0);
        apply_stimulus(3'd6, 32'd5, 32'd5, 8'd0);
        check_output("op6_busy", 32'(busy), 32'd0);
        check_output("op6_hi", hi, 32'hDEADBEEF);

        apply_stimulus(3'd5, 32'hCAFEBABE, 32'd0, 8'd0);
        check_output("mtlo_lo", lo, 32'hCAFEBABE);
        check_output("mtlo_busy", 32'(busy), 32'd0);

        // Reset at E20 discards the operation and clears HI/LO.
        apply_stimulus(3'd0, 32'd9, 32'd9, 8'd0);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            rst = (k == 19);
        end
        check_output("rst_hi", hi, 32'd0);
        check_output("rst_lo", lo, 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);

        check_output("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
